return_stack_unit: RTL and testbench
====================================

RETURN_STACK_UNIT -- requirements
Module: return_stack_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of return-address entries (power of two, 2..64).
REQ-002 SHALL have parameter WIDTH, default 32, return-address width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-005 SHALL have port push  input  1  push request; JAL in datapath.
REQ-006 SHALL have port pop  input  1  pop request; return via stop bit in datapath.
REQ-007 SHALL have port push_data  input  WIDTH  return address to store (next_pc of the JAL).
REQ-008 SHALL have port clear_err  input  1  synchronous clear of sticky error flags.
REQ-009 SHALL have port top_data  output  WIDTH  entry at top of stack (RA to the pc mux).
REQ-010 SHALL have port count  output  log2(DEPTH)+1  current number of valid entries.
REQ-011 SHALL have port empty  output  1  high when count == 0.
REQ-012 SHALL have port full  output  1  high when count == DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: push rejected because stack was full.
REQ-014 SHALL have port underflow  output  1  sticky: pop rejected because stack was empty.

Function
REQ-015 SHALL hold entries in an internal array of DEPTH x WIDTH registers plus a pointer sp = count.
REQ-016 SHALL, on push only with count < DEPTH, write push_data to entry[sp] and increment count by 1 at the same edge.
REQ-017 SHALL, on pop only with count > 0, decrement count by 1; entry contents are not cleared.
REQ-018 SHALL, on push and pop in the same cycle with count > 0, overwrite entry[count-1] with push_data and leave count unchanged; no flag changes, even when full.
REQ-019 SHALL, on push and pop in the same cycle with count == 0, perform the push (count becomes 1, entry[0] = push_data) and set underflow.
REQ-020 SHALL, on push only with count == DEPTH, leave count and all entries unchanged and set overflow.
REQ-021 SHALL, on pop only with count == 0, leave count unchanged and set underflow.
REQ-022 SHALL drive top_data combinationally as entry[count-1] when count > 0, and all zeros when empty; a write updates top_data after the edge (zero-cycle read latency after the update).
REQ-023 SHALL derive empty, full and count combinationally from the pointer register only.
REQ-024 SHALL clear overflow and underflow on clear_err at the rising edge; a new error event in the same cycle as clear_err takes priority and sets the flag.
REQ-025 SHALL treat count arithmetic with no wrap-around: count never exceeds DEPTH and never goes below 0.
REQ-026 SHALL operate without a state machine beyond the pointer and flags; every push/pop request completes in one cycle, no handshake stall.

Reset
REQ-027 SHALL, while reset == 0, asynchronously force count = 0, overflow = 0, underflow = 0; empty = 1, full = 0, top_data = 0.
REQ-028 SHALL leave array contents undefined-but-unobservable after reset; top_data is 0 until the first push.
REQ-029 SHALL ignore push, pop and clear_err while reset is asserted; reset asserted mid-operation aborts the pending edge's update.
REQ-030 SHALL resume normal operation on the first rising clk edge after reset returns to 1.

Verification
REQ-031 Reset then push 0x00000010, 0x00000020 on consecutive cycles -> count = 2, top_data = 0x00000020, empty = 0.
REQ-032 From that state pop twice, then pop once more -> top_data 0x00000010 then 0; count = 0; underflow = 1 after the third pop, count stays 0.
REQ-033 DEPTH = 8: push 0x1..0x8, then push 0x9 -> full = 1, overflow = 1, count = 8, top_data = 0x00000008.
REQ-034 count = 3, top 0x00000030; assert push (0x00000099) and pop together -> count = 3, top_data = 0x00000099, no flags set.
REQ-035 Empty stack, push (0x00000044) and pop together -> count = 1, top_data = 0x00000044, underflow = 1; then clear_err -> underflow = 0.
REQ-036 count = 5, assert reset = 0 asynchronously between edges -> count = 0, empty = 1, top_data = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/return_stack_unit.sv
// Purpose : hardware return-address stack (push on JAL, pop on return) feeding the pc mux.
// Latency : push/pop complete at the rising edge; top_data reflects the new top right after that edge.
// Backpressure: none; every request completes in one cycle, and rejected requests raise sticky error flags.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous active-low reset (0 = asserted)
//   push       - push request (JAL in the datapath)
//   pop        - pop request (return in the datapath)
//   push_data  - return address to store (next_pc of the JAL)
//   clear_err  - synchronous clear of the sticky overflow/underflow flags
//   top_data   - entry at the top of the stack, zero when empty
//   count      - number of valid entries (0..DEPTH)
//   empty      - count == 0
//   full       - count == DEPTH
//   overflow   - sticky: a push was rejected because the stack was full
//   underflow  - sticky: a pop was rejected because the stack was empty
module return_stack_unit #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       clear_err,
   output logic [WIDTH-1:0]           top_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   // AW indexes the array; PW holds 0..DEPTH inclusive, so it needs one more bit.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] entry [DEPTH];
   logic [PW-1:0]    sp;
   logic [PW-1:0]    sp_m1;
   logic [PW-1:0]    sp_nxt;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;
   logic             wr_en;
   logic             set_ovf;
   logic             set_udf;
   logic             ovf_nxt;
   logic             udf_nxt;

   // Status flags come from the pointer alone.
   assign count   = sp;
   assign empty   = (sp == '0);
   assign full    = (sp == PW'(DEPTH));

   assign sp_m1   = sp - PW'(1);
   assign top_idx = sp_m1[AW-1:0];

   // When empty the array contents are stale or undefined, so mask them off.
   assign top_data = empty ? '0 : entry[top_idx];

   // Next-state decode for the pointer, the array write and the error flags.
   always_comb begin
      sp_nxt  = sp;
      wr_en   = 1'b0;
      wr_idx  = sp[AW-1:0];
      set_ovf = 1'b0;
      set_udf = 1'b0;

      if (push && pop) begin
         if (!empty) begin
            // Return immediately followed by a call: replace the top in place.
            wr_en  = 1'b1;
            wr_idx = top_idx;
         end else begin
            // Nothing to pop: the push still happens, the pop is flagged.
            wr_en   = 1'b1;
            wr_idx  = '0;
            sp_nxt  = PW'(1);
            set_udf = 1'b1;
         end
      end else if (push) begin
         if (!full) begin
            wr_en  = 1'b1;
            wr_idx = sp[AW-1:0];
            sp_nxt = sp + PW'(1);
         end else begin
            set_ovf = 1'b1;
         end
      end else if (pop) begin
         if (!empty) begin
            sp_nxt = sp_m1;
         end else begin
            set_udf = 1'b1;
         end
      end

      // A fresh error in the same cycle as clear_err wins.
      ovf_nxt = set_ovf | (overflow  & ~clear_err);
      udf_nxt = set_udf | (underflow & ~clear_err);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         sp        <= sp_nxt;
         overflow  <= ovf_nxt;
         underflow <= udf_nxt;
      end
   end

   // The array needs no reset: top_data is masked while the pointer is zero.
   // Writes are still gated by reset so an edge during reset changes nothing.
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         entry[wr_idx] <= push_data;
      end
   end

endmodule

// File: tb/tb_return_stack_unit.sv
// Purpose : directed self-checking bench for return_stack_unit (DEPTH=8, WIDTH=32).
// Latency : inputs driven after a falling edge, outputs checked on the next falling edge.
// Backpressure: none exercised; the design never stalls.
module tb_return_stack_unit;

   logic        clk;
   logic        reset;
   logic        push;
   logic        pop;
   logic [31:0] push_data;
   logic        clear_err;
   logic [31:0] top_data;
   logic [3:0]  count;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        underflow;

   int total = 0;
   int bad   = 0;

   return_stack_unit #(.DEPTH(8), .WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .clear_err (clear_err),
      .top_data  (top_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one request for one rising edge, then return to idle at the next falling edge.
   task automatic step(input logic p, input logic q, input logic [31:0] d, input logic ce);
      push      = p;
      pop       = q;
      push_data = d;
      clear_err = ce;
      @(negedge clk);
      push      = 1'b0;
      pop       = 1'b0;
      push_data = '0;
      clear_err = 1'b0;
   endtask

   task automatic chk_state(input string tag, input int c, input logic [31:0] t,
                            input logic e, input logic f, input logic o, input logic u);
      chk({tag, ".count"},     32'(count),     32'(c));
      chk({tag, ".top"},       top_data,       t);
      chk({tag, ".empty"},     32'(empty),     32'(e));
      chk({tag, ".full"},      32'(full),      32'(f));
      chk({tag, ".overflow"},  32'(overflow),  32'(o));
      chk({tag, ".underflow"}, 32'(underflow), 32'(u));
   endtask

   // Pulse reset low between edges and check that it acts without a clock edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_state(tag, 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = '0;
      clear_err = 1'b0;

      // Reset state.
      @(negedge clk);
      chk_state("rst", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Requests while reset is held must be ignored.
      step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
      chk_state("rst_ign", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      // Two pushes.
      step(1'b1, 1'b0, 32'h10, 1'b0);
      chk_state("push1", 1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h20, 1'b0);
      chk_state("push2", 2, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);

      // Pop back to empty, then one pop too many.
      step(1'b0, 1'b1, 32'h0, 1'b0);
      chk_state("pop1", 1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      chk_state("pop2", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      chk_state("pop3", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk_state("clr_udf", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Fill to DEPTH, then overflow.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 32'(i), 1'b0);
      end
      chk_state("fill", 8, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h9, 1'b0);
      chk_state("ovf", 8, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0);

      // Push+pop while full replaces the top and leaves the flags alone.
      step(1'b1, 1'b1, 32'hAA, 1'b0);
      chk_state("pp_full", 8, 32'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk_state("clr_ovf", 8, 32'hAA, 1'b0, 1'b1, 1'b0, 1'b0);

      // A new overflow in the same cycle as clear_err wins.
      step(1'b1, 1'b0, 32'hBB, 1'b1);
      chk_state("ovf_vs_clr", 8, 32'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      chk_state("pop_after_pp", 7, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0);

      async_reset("areset_a");

      // Push+pop with count=3 replaces only the top entry.
      step(1'b1, 1'b0, 32'h10, 1'b0);
      step(1'b1, 1'b0, 32'h20, 1'b0);
      step(1'b1, 1'b0, 32'h30, 1'b0);
      chk_state("three", 3, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h99, 1'b0);
      chk_state("pp3", 3, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      chk_state("pp3_pop", 2, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);

      // Build count=5, then reset asynchronously between edges.
      step(1'b1, 1'b0, 32'h40, 1'b0);
      step(1'b1, 1'b0, 32'h50, 1'b0);
      step(1'b1, 1'b0, 32'h60, 1'b0);
      chk_state("five", 5, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0);
      async_reset("areset_b");

      // Push+pop on an empty stack pushes and flags underflow.
      step(1'b1, 1'b1, 32'h44, 1'b0);
      chk_state("pp_empty", 1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk_state("pp_clr", 1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0);

      // Underflow raised alongside clear_err stays set.
      step(1'b0, 1'b1, 32'h0, 1'b0);
      chk_state("drain", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b1);
      chk_state("udf_vs_clr", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
